nav_update_sched: RTL

//  Epoch scheduler and arbiter in front of the navigation datapath. Several measurement

---
 rtl/nav_update_sched.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/nav_update_sched.sv
// Epoch scheduler/arbiter feeding nav_processor: one granted pos/vel per epoch, miss tracking.
// Define NAV_SCHED_FIXED_PRIO_EN for fixed priority (source 0 highest); default is round-robin.
//
// state | meaning
// IDLE  | stopped, epoch counter held at 0
// WAIT  | running, waiting for end of epoch
// ARB   | polling sources every cycle for a grant
// ISSUE | nav_load strobe cycle
module nav_update_sched #(
    parameter int NUM_SRC      = 4,
    parameter int DW           = 32,
    parameter int EPOCH_CYCLES = 1000,
    parameter int MISS_W       = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic [NUM_SRC-1:0]         src_valid,
    output logic [NUM_SRC-1:0]         src_ready,
    input  logic [NUM_SRC*DW-1:0]      src_pos,
    input  logic [NUM_SRC*DW-1:0]      src_vel,
    output logic [DW-1:0]              nav_pos,
    output logic [DW-1:0]              nav_vel,
    output logic                       nav_load,
    output logic [$clog2(NUM_SRC)-1:0] grant_id,
    output logic                       epoch_tick,
    output logic                       stale,
    output logic [MISS_W-1:0]          miss_cnt
);

    localparam int GW = $clog2(NUM_SRC);
    localparam int CW = $clog2(EPOCH_CYCLES);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_ARB   = 2'd2;
    localparam logic [1:0] S_ISSUE = 2'd3;

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [CW-1:0] epoch_cnt;
    logic [GW-1:0] last_grant;
    logic [GW-1:0] hit_idx;
    logic          hit;
    logic          grant_fire;
    logic          tick_int;
    int            search_start;

    assign tick_int   = (state != S_IDLE) && (epoch_cnt == CW'(EPOCH_CYCLES - 1));
    assign epoch_tick = tick_int;

`ifdef NAV_SCHED_FIXED_PRIO_EN
    assign search_start = 0;
`else
    assign search_start = int'(last_grant) + 1;
`endif

    // First valid source walking upward from search_start, wrapping at NUM_SRC.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (!hit && src_valid[(search_start + k) % NUM_SRC]) begin
                hit     = 1'b1;
                hit_idx = GW'((search_start + k) % NUM_SRC);
            end
        end
    end

    assign grant_fire = (state == S_ARB) && enable && hit;

    always_comb begin
        src_ready = '0;
        if (grant_fire) begin
            src_ready[hit_idx] = 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (enable) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (!enable)       state_nxt = S_IDLE;
                else if (tick_int) state_nxt = S_ARB;
            end
            S_ARB: begin
                if (!enable)  state_nxt = S_IDLE;
                else if (hit) state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                if (!enable)       state_nxt = S_IDLE;
                else if (tick_int) state_nxt = S_ARB;
                else               state_nxt = S_WAIT;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            epoch_cnt <= '0;
        end else begin
            state <= state_nxt;
            // The cycle enable is first seen in IDLE counts as epoch cycle 0.
            if (state_nxt == S_IDLE) begin
                epoch_cnt <= '0;
            end else if (tick_int) begin
                epoch_cnt <= '0;
            end else begin
                epoch_cnt <= epoch_cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nav_pos    <= '0;
            nav_vel    <= '0;
            nav_load   <= 1'b0;
            grant_id   <= '0;
            last_grant <= GW'(NUM_SRC - 1);
            stale      <= 1'b0;
            miss_cnt   <= '0;
        end else begin
            nav_load <= grant_fire;
            if (grant_fire) begin
                nav_pos    <= src_pos[int'(hit_idx)*DW +: DW];
                nav_vel    <= src_vel[int'(hit_idx)*DW +: DW];
                grant_id   <= hit_idx;
                last_grant <= hit_idx;
                stale      <= 1'b0;
            end else if ((state == S_ARB) && enable && tick_int) begin
                stale <= 1'b1;
                if (miss_cnt != {MISS_W{1'b1}}) begin
                    miss_cnt <= miss_cnt + MISS_W'(1);
                end
            end
        end
    end

endmodule
